// File: rtl/calc_engine.sv
// Pocket-calculator engine: edge-detected key commands, accumulator/entry datapath,
// single-cycle add/sub/mul and an iterative restoring divider. Optional CALC_SAT_EN saturates overflows.
module calc_engine #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_pwr,
    input  logic                    i_clr,
    input  logic                    i_neg,
    input  logic                    i_eq,
    input  logic                    i_digit_req,
    input  logic [3:0]              i_digit,
    input  logic                    i_op_req,
    input  logic [1:0]              i_op,
    output logic signed [WIDTH-1:0] o_display,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_ovf,
    output logic [2:0]              o_state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_CLEAR = 3'd1,
        S_ENTRY = 3'd2,
        S_EXEC  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam int CW = $clog2(WIDTH + 2);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]           DIV_LAST = CW'(WIDTH);
    localparam logic [DW-1:0]           DMAX     = DW'(MAX_DIGITS);
    localparam logic signed [WIDTH-1:0] TEN      = WIDTH'(10);

    state_t r_state;
    state_t w_next;

    logic r_clr_q, r_neg_q, r_eq_q, r_dig_q, r_op_q;
    logic w_clr_e, w_neg_e, w_eq_e, w_dig_e, w_op_e;
    logic w_ev_exec, w_ev_neg, w_ev_dig;

    logic signed [WIDTH-1:0] r_acc, r_entry, r_display;
    logic [DW-1:0]           r_count;
    logic [1:0]              r_pop, r_exec_op, r_new_op;
    logic                    r_fresh, r_new_fresh, r_ovf;
    logic [CW-1:0]           r_cnt;
    logic [WIDTH-1:0]        r_rem, r_quo;

    // Commands fire only on the cycle the key first reads high.
    assign w_clr_e = i_clr & ~r_clr_q;
    assign w_neg_e = i_neg & ~r_neg_q;
    assign w_eq_e  = i_eq & ~r_eq_q;
    assign w_dig_e = i_digit_req & ~r_dig_q;
    assign w_op_e  = i_op_req & ~r_op_q;

    assign w_ev_exec = ~w_clr_e & (w_eq_e | w_op_e);
    assign w_ev_neg  = ~w_clr_e & ~w_eq_e & ~w_op_e & w_neg_e;
    assign w_ev_dig  = ~w_clr_e & ~w_eq_e & ~w_op_e & ~w_neg_e & w_dig_e;

    logic signed [WIDTH-1:0] w_dig_ext, w_entry_x10, w_entry_dig, w_entry_neg;
    logic                    w_dig_ok;

    assign w_dig_ext   = {{(WIDTH-4){1'b0}}, i_digit};
    assign w_entry_x10 = r_entry * TEN;
    assign w_entry_dig = r_entry[WIDTH-1] ? (w_entry_x10 - w_dig_ext) : (w_entry_x10 + w_dig_ext);
    assign w_entry_neg = -r_entry;
    assign w_dig_ok    = (i_digit <= 4'd9) && (r_count < DMAX);

    // Add/sub/mul are evaluated at double width so overflow is visible in the upper bits.
    logic signed [2*WIDTH-1:0] w_a_ext, w_b_ext, w_fast_wide;
    logic [WIDTH:0]            w_fast_hi;
    logic                      w_fast_ovf;

    assign w_a_ext = {{WIDTH{r_acc[WIDTH-1]}}, r_acc};
    assign w_b_ext = {{WIDTH{r_entry[WIDTH-1]}}, r_entry};

    always_comb begin
        w_fast_wide = '0;
        case (r_exec_op)
            OP_ADD:  w_fast_wide = w_a_ext + w_b_ext;
            OP_SUB:  w_fast_wide = w_a_ext - w_b_ext;
            OP_MUL:  w_fast_wide = w_a_ext * w_b_ext;
            default: w_fast_wide = '0;
        endcase
    end

    assign w_fast_hi  = w_fast_wide[2*WIDTH-1:WIDTH-1];
    assign w_fast_ovf = ~((&w_fast_hi) | ~(|w_fast_hi));

    // Restoring division on magnitudes; one quotient bit per EXEC cycle after a load cycle.
    logic [WIDTH-1:0] w_acc_mag, w_ent_mag, w_quo_nx, w_rem_nx;
    logic [WIDTH:0]   w_rem_sh, w_sub, w_div_mag, w_div_res;
    logic             w_ge, w_qneg, w_div_ovf;

    assign w_acc_mag = r_acc[WIDTH-1] ? ($unsigned(~r_acc) + 1'b1) : $unsigned(r_acc);
    assign w_ent_mag = r_entry[WIDTH-1] ? ($unsigned(~r_entry) + 1'b1) : $unsigned(r_entry);
    assign w_qneg    = r_acc[WIDTH-1] ^ r_entry[WIDTH-1];
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_sub     = w_rem_sh - {1'b0, w_ent_mag};
    assign w_ge      = ~w_sub[WIDTH];
    assign w_quo_nx  = {r_quo[WIDTH-2:0], w_ge};
    assign w_rem_nx  = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_mag = {1'b0, w_quo_nx};
    assign w_div_res = w_qneg ? (~w_div_mag + 1'b1) : w_div_mag;
    assign w_div_ovf = w_div_res[WIDTH] ^ w_div_res[WIDTH-1];

    logic                    w_is_div, w_div_zero, w_exec_last, w_ovf, w_res_neg;
    logic                    w_fail, w_sat_hit;
    logic signed [WIDTH-1:0] w_trunc, w_result;

    assign w_is_div    = (r_exec_op == OP_DIV);
    assign w_div_zero  = w_is_div && (r_cnt == '0) && (r_entry == '0);
    assign w_exec_last = w_is_div ? (r_cnt == DIV_LAST) : 1'b1;
    assign w_ovf       = w_is_div ? w_div_ovf : w_fast_ovf;
    assign w_res_neg   = w_is_div ? w_div_res[WIDTH] : w_fast_wide[2*WIDTH-1];
    assign w_trunc     = w_is_div ? w_div_res[WIDTH-1:0] : w_fast_wide[WIDTH-1:0];

`ifdef CALC_SAT_EN
    logic signed [WIDTH-1:0] w_sat_val;
    assign w_sat_val = w_res_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_fail    = w_div_zero;
    assign w_sat_hit = w_exec_last & w_ovf;
    assign w_result  = w_ovf ? w_sat_val : w_trunc;
`else
    logic w_unused;
    assign w_unused  = w_res_neg;
    assign w_fail    = w_div_zero | (w_exec_last & w_ovf);
    assign w_sat_hit = 1'b0;
    assign w_result  = w_trunc;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_OFF;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_OFF:   if (i_pwr) w_next = S_CLEAR;
            S_CLEAR: w_next = S_ENTRY;
            S_ENTRY: begin
                if (w_clr_e)        w_next = S_CLEAR;
                else if (w_ev_exec) w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_fail)           w_next = S_ERROR;
                else if (w_exec_last) w_next = S_ENTRY;
            end
            S_ERROR: if (w_clr_e) w_next = S_CLEAR;
            default: w_next = S_OFF;
        endcase
        if (!i_pwr) w_next = S_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            r_eq_q      <= 1'b0;
            r_dig_q     <= 1'b0;
            r_op_q      <= 1'b0;
            r_acc       <= '0;
            r_entry     <= '0;
            r_display   <= '0;
            r_count     <= '0;
            r_pop       <= OP_ADD;
            r_exec_op   <= OP_ADD;
            r_new_op    <= OP_ADD;
            r_fresh     <= 1'b0;
            r_new_fresh <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
        end else begin
            r_clr_q <= i_clr;
            r_neg_q <= i_neg;
            r_eq_q  <= i_eq;
            r_dig_q <= i_digit_req;
            r_op_q  <= i_op_req;
            if (!i_pwr) begin
                r_display <= '0;
                r_ovf     <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        r_display <= '0;
                        r_ovf     <= 1'b0;
                    end
                    S_CLEAR: begin
                        r_acc     <= '0;
                        r_entry   <= '0;
                        r_count   <= '0;
                        r_pop     <= OP_ADD;
                        r_fresh   <= 1'b0;
                        r_display <= '0;
                        r_ovf     <= 1'b0;
                    end
                    S_ENTRY: begin
                        if (w_ev_exec) begin
                            r_exec_op   <= r_pop;
                            r_new_op    <= w_eq_e ? OP_ADD : i_op;
                            r_new_fresh <= w_eq_e;
                            r_cnt       <= '0;
                        end else if (w_ev_neg) begin
                            r_entry   <= w_entry_neg;
                            r_display <= w_entry_neg;
                        end else if (w_ev_dig && w_dig_ok) begin
                            // First digit after '=' starts a new chain.
                            if (r_fresh) begin
                                r_acc   <= '0;
                                r_pop   <= OP_ADD;
                                r_fresh <= 1'b0;
                            end
                            r_entry   <= w_entry_dig;
                            r_count   <= r_count + 1'b1;
                            r_display <= w_entry_dig;
                        end
                    end
                    S_EXEC: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == '0) begin
                            r_rem <= '0;
                            r_quo <= w_acc_mag;
                        end else begin
                            r_rem <= w_rem_nx;
                            r_quo <= w_quo_nx;
                        end
                        if (w_fail) begin
                            r_display <= '0;
                        end else if (w_exec_last) begin
                            r_acc     <= w_result;
                            r_display <= w_result;
                            r_entry   <= '0;
                            r_count   <= '0;
                            r_pop     <= r_new_op;
                            r_fresh   <= r_new_fresh;
                            if (w_sat_hit) r_ovf <= 1'b1;
                        end
                    end
                    S_ERROR: r_display <= '0;
                    default: r_display <= '0;
                endcase
            end
        end
    end

    assign o_display = r_display;
    assign o_busy    = (r_state == S_EXEC);
    assign o_err     = (r_state == S_ERROR);
    assign o_ovf     = r_ovf;
    assign o_state   = r_state;

endmodule

// File: tb/tb_calc_engine.sv
// Directed and randomized key sequences for calc_engine, checked against an arithmetic
// model of the calculator (accumulator, entry, pending operator) held in the bench.
module tb_calc_engine;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwr = 1'b0;
  logic clr = 1'b0;
  logic neg = 1'b0;
  logic eq = 1'b0;
  logic digit_req = 1'b0;
  logic [3:0] digit = 4'd0;
  logic op_req = 1'b0;
  logic [1:0] op = 2'd0;
  logic signed [W-1:0] display;
  logic busy, err, ovf;
  logic [2:0] dbg_state;

  calc_engine #(.WIDTH(W), .MAX_DIGITS(9)) dut (
    .clk(clk), .rst(rst), .i_pwr(pwr), .i_clr(clr), .i_neg(neg), .i_eq(eq),
    .i_digit_req(digit_req), .i_digit(digit), .i_op_req(op_req), .i_op(op),
    .o_display(display), .o_busy(busy), .o_err(err), .o_ovf(ovf), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // Reference calculator
  longint m_acc, m_entry, m_disp;
  int m_count, m_pend;
  bit m_fresh, m_err, m_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_display"}, display, m_disp);
    check({tag, "_err"}, err, m_err);
    check({tag, "_ovf"}, ovf, m_ovf);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic model_clear();
    m_acc = 0; m_entry = 0; m_disp = 0; m_count = 0; m_pend = 0;
    m_fresh = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_digit(input int d);
    if (m_err || d > 9 || m_count == 9) return;
    if (m_fresh) begin
      m_acc = 0; m_pend = 0; m_fresh = 0;
    end
    m_entry = (m_entry < 0) ? m_entry * 10 - d : m_entry * 10 + d;
    m_count++;
    m_disp = m_entry;
  endtask

  task automatic model_exec(input bit is_eq, input int o);
    longint r;
    if (m_err) return;
    case (m_pend)
      0: r = m_acc + m_entry;
      1: r = m_acc - m_entry;
      2: r = m_acc * m_entry;
      default: begin
        if (m_entry == 0) begin
          m_err = 1; m_disp = 0;
          return;
        end
        r = m_acc / m_entry;
      end
    endcase
    if (r > SMAX || r < SMIN) begin
`ifdef CALC_SAT_EN
      r = (r > SMAX) ? SMAX : SMIN;
      m_ovf = 1;
`else
      m_err = 1; m_disp = 0;
      return;
`endif
    end
    m_acc = r; m_disp = r; m_entry = 0; m_count = 0;
    m_pend = is_eq ? 0 : o;
    m_fresh = is_eq;
  endtask

  // Level keys: 0 clr, 1 neg, 2 digit; held 1..3 cycles then released.
  task automatic hold_key(input int k, input int d);
    int h;
    h = $urandom_range(1, 3);
    case (k)
      0: clr = 1'b1;
      1: neg = 1'b1;
      default: begin digit_req = 1'b1; digit = d[3:0]; end
    endcase
    repeat (h) tick();
    clr = 1'b0; neg = 1'b0; digit_req = 1'b0;
    tick();
  endtask

  task automatic press_digit(input int d);
    hold_key(2, d);
    model_digit(d);
    check_state("digit");
  endtask

  task automatic press_neg();
    hold_key(1, 0);
    if (!m_err) begin
      m_entry = -m_entry;
      m_disp = m_entry;
    end
    check_state("neg");
  endtask

  task automatic press_clr();
    hold_key(0, 0);
    model_clear();
    check_state("clr");
  endtask

  task automatic exec_key(input bit is_eq, input int o, input string tag);
    int h, cyc, exp_cyc;
    bit chk_cyc;
    chk_cyc = 1;
    if (m_err) exp_cyc = 0;
    else if (m_pend == 3) begin
      exp_cyc = W + 1;
      if (m_entry == 0) chk_cyc = 0;
    end else exp_cyc = 1;
    if (is_eq) eq = 1'b1;
    else begin op_req = 1'b1; op = o[1:0]; end
    h = $urandom_range(1, 3);
    tick();
    h--;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (h <= 0) begin eq = 1'b0; op_req = 1'b0; end
      if (cyc == 3) begin digit_req = 1'b1; digit = 4'd8; end
      if (cyc == 4) digit_req = 1'b0;
      cyc++;
      tick();
      h--;
    end
    eq = 1'b0; op_req = 1'b0; digit_req = 1'b0;
    tick();
    if (chk_cyc) check({tag, "_busy_cycles"}, cyc, exp_cyc);
    model_exec(is_eq, o);
    check_state(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int ncnt, nops;
    model_clear();
    // Reset dominates even with power requested
    repeat (2) tick();
    pwr = 1'b1;
    tick();
    check_state("reset");
    rst = 1'b0;
    tick();
    tick();
    check_state("power_up");

    // 12 + 34 =
    press_digit(1);
    press_digit(2);
    check("r035_12", display, 12);
    exec_key(0, 0, "r035_add");
    press_digit(3);
    press_digit(4);
    check("r035_34", display, 34);
    exec_key(1, 0, "r035_eq");
    check("r035_46", display, 46);

    // -100 / 7 = -14, then fresh entry
    press_clr();
    press_digit(1); press_digit(0); press_digit(0);
    press_neg();
    check("r036_neg", display, -100);
    exec_key(0, 3, "r036_divop");
    press_digit(7);
    exec_key(1, 0, "r036_eq");
    check("r036_quot", display, -14);
    press_digit(5);
    check("r036_fresh", display, 5);
    exec_key(1, 0, "r036_fresh_eq");
    check("r036_acc_cleared", display, 5);

    // Divide by zero
    press_clr();
    press_digit(5);
    exec_key(0, 3, "r037_divop");
    press_digit(0);
    exec_key(1, 0, "r037_eq");
    check("r037_err", err, 1);
    press_digit(3);
    exec_key(0, 0, "r037_op_ignored");
    check("r037_still_err", err, 1);
    press_clr();
    check("r037_cleared", err, 0);

    // Build 2147483647 then add 1
    press_clr();
    press_digit(2); press_digit(1); press_digit(4); press_digit(7); press_digit(4);
    press_digit(8); press_digit(3); press_digit(6); press_digit(4);
    exec_key(0, 2, "r038_mulop");
    press_digit(1); press_digit(0);
    exec_key(0, 0, "r038_x10");
    press_digit(7);
    exec_key(0, 0, "r038_plus7");
    check("r038_max", display, SMAX);
    press_digit(1);
    exec_key(1, 0, "r038_ovf");
`ifdef CALC_SAT_EN
    check("r038_sat_display", display, SMAX);
    check("r038_sat_ovf", ovf, 1);
    check("r038_sat_err", err, 0);
`else
    check("r038_err", err, 1);
    check("r038_err_display", display, 0);
`endif

    // Digit limit and same-cycle digit+op
    press_clr();
    for (int i = 0; i < 10; i++) press_digit(9);
    check("r039_nines", display, 999999999);
    press_clr();
    press_digit(3);
    digit_req = 1'b1; digit = 4'd4; op_req = 1'b1; op = 2'd1;
    tick();
    ncnt = 0;
    while (busy && ncnt < 100) begin
      digit_req = 1'b0; op_req = 1'b0;
      ncnt++;
      tick();
    end
    digit_req = 1'b0; op_req = 1'b0;
    tick();
    check("r039_busy_cycles", ncnt, 1);
    model_exec(0, 1);
    check_state("r039_op_only");
    press_digit(1);
    exec_key(1, 0, "r039_eq");
    check("r039_result", display, 2);

    // Randomized chains
    for (int s = 0; s < 30; s++) begin
      press_clr();
      nops = $urandom_range(1, 4);
      for (int k = 0; k < nops; k++) begin
        ncnt = $urandom_range(1, 5);
        for (int j = 0; j < ncnt; j++) press_digit($urandom_range(0, 11));
        if ($urandom_range(0, 3) == 0) press_neg();
        if (k == nops - 1) exec_key(1, 0, "rnd_eq");
        else exec_key(0, $urandom_range(0, 3), "rnd_op");
      end
      if ($urandom_range(0, 1) == 1) begin
        press_digit($urandom_range(0, 9));
        exec_key(1, 0, "rnd_fresh_eq");
      end
    end

    // Reset in the middle of a division
    press_clr();
    press_digit(1); press_digit(0); press_digit(0);
    exec_key(0, 3, "r040_divop");
    press_digit(7);
    eq = 1'b1;
    tick();
    repeat (9) tick();
    check("r040_busy_mid", busy, 1);
    rst = 1'b1;
    eq = 1'b0;
    tick();
    model_clear();
    check_state("r040_rst");
    rst = 1'b0;
    tick();
    tick();
    press_digit(5);
    check("r040_entry_after", display, 5);

    // Power loss aborts a division
    exec_key(0, 3, "pwr_divop");
    press_digit(3);
    eq = 1'b1;
    tick();
    repeat (4) tick();
    pwr = 1'b0;
    eq = 1'b0;
    tick();
    model_clear();
    check_state("pwr_off");
    pwr = 1'b1;
    tick();
    tick();
    press_digit(6);
    check("pwr_on_entry", display, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
